// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Single-entry ID/EX issue register in front of the 64-bit ALU. It takes one
// decoded LEGv8 instruction plus its register-file read data, turns the
// 11-bit opcode into the ALU's 4-bit select code, and resolves both operands.
// Each operand is either XZR, a same-cycle write-back forward, the immediate
// or the register-file value. The result is held in a register and handed to
// the ALU with a valid/ready handshake. A free-running counter records every
// completed output handshake.
//
// Parameters
//   DATA_W       operand width (must match the ALU input width)
//   CNT_W        issue counter width
//
// Ports
//   clk, rst_n   clock; asynchronous active-low reset
//   in_valid     upstream offers an instruction
//   in_ready     stage can take an instruction this cycle (never uses in_valid)
//   opcode       instruction bits [31:21]
//   rn_idx/rm_idx/rd_idx  source and destination register numbers
//   rn_data/rm_data       register-file read data
//   imm          pre-sign-extended immediate, used verbatim
//   wb_we/wb_rd/wb_data   write-back port, used for same-cycle forwarding
//   flush        drop the held instruction and any instruction offered now
//   out_valid    ALU operands valid
//   out_ready    ALU/EX side consumes this cycle
//   select       ALU operation code
//   input1/2     ALU operands
//   out_rd       destination register carried to EX
//   out_illegal  opcode did not decode (still issued and counted)
//   issue_count  number of completed output handshakes, wraps
// ---------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [10:0]       opcode,
  input  logic [4:0]        rn_idx,
  input  logic [4:0]        rm_idx,
  input  logic [4:0]        rd_idx,
  input  logic [DATA_W-1:0] rn_data,
  input  logic [DATA_W-1:0] rm_data,
  input  logic [DATA_W-1:0] imm,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        select,
  output logic [DATA_W-1:0] input1,
  output logic [DATA_W-1:0] input2,
  output logic [4:0]        out_rd,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  issue_count
);

  // ALU operation codes.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ORR = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [4:0] XZR = 5'd31;

  // Operand source for input1 / input2.
  localparam logic [1:0] SRC_ZERO = 2'd0;
  localparam logic [1:0] SRC_RN   = 2'd1;
  localparam logic [1:0] SRC_RM   = 2'd2;
  localparam logic [1:0] SRC_IMM  = 2'd3;

  // -------------------------------------------------------------------------
  // Operand resolution: XZR wins over forwarding, forwarding wins over the
  // register file. A write-back to XZR is never forwarded.
  // -------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] resolve_operand(
    input logic [4:0]        idx,
    input logic [DATA_W-1:0] rf_data,
    input logic              fwd_we,
    input logic [4:0]        fwd_rd,
    input logic [DATA_W-1:0] fwd_data
  );
    if (idx == XZR) begin
      resolve_operand = '0;
    end else if (fwd_we && (fwd_rd == idx) && (fwd_rd != XZR)) begin
      resolve_operand = fwd_data;
    end else begin
      resolve_operand = rf_data;
    end
  endfunction

  logic [DATA_W-1:0] rn_val;
  logic [DATA_W-1:0] rm_val;

  assign rn_val = resolve_operand(rn_idx, rn_data, wb_we, wb_rd, wb_data);
  assign rm_val = resolve_operand(rm_idx, rm_data, wb_we, wb_rd, wb_data);

  // -------------------------------------------------------------------------
  // Opcode decode
  // -------------------------------------------------------------------------
  logic [3:0] dec_select;
  logic [1:0] dec_src1;
  logic [1:0] dec_src2;
  logic       dec_illegal;

  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // through the case leaves one unassigned, which would infer a latch.
    dec_select  = ALU_AND;
    dec_src1    = SRC_ZERO;
    dec_src2    = SRC_ZERO;
    dec_illegal = 1'b0;

    casez (opcode)
      11'b10001011000: begin // ADD
        dec_select = ALU_ADD;
        dec_src1   = SRC_RN;
        dec_src2   = SRC_RM;
      end
      11'b11001011000: begin // SUB
        dec_select = ALU_SUB;
        dec_src1   = SRC_RN;
        dec_src2   = SRC_RM;
      end
      11'b10001010000: begin // AND
        dec_select = ALU_AND;
        dec_src1   = SRC_RN;
        dec_src2   = SRC_RM;
      end
      11'b10101010000: begin // ORR
        dec_select = ALU_ORR;
        dec_src1   = SRC_RN;
        dec_src2   = SRC_RM;
      end
      11'b1001000100?: begin // ADDI
        dec_select = ALU_ADD;
        dec_src1   = SRC_RN;
        dec_src2   = SRC_IMM;
      end
      11'b1101000100?: begin // SUBI
        dec_select = ALU_SUB;
        dec_src1   = SRC_RN;
        dec_src2   = SRC_IMM;
      end
      11'b11111000010,       // LDUR
      11'b11111000000: begin // STUR
        dec_select = ALU_ADD;
        dec_src1   = SRC_RN;
        dec_src2   = SRC_IMM;
      end
      11'b10110100???: begin // CBZ: compare Rt (carried on rm) against zero
        dec_select = ALU_ADD;
        dec_src1   = SRC_ZERO;
        dec_src2   = SRC_RM;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Operand muxes driven by the decoded source selects.
  function automatic logic [DATA_W-1:0] pick_operand(
    input logic [1:0]        src,
    input logic [DATA_W-1:0] rn_v,
    input logic [DATA_W-1:0] rm_v,
    input logic [DATA_W-1:0] imm_v
  );
    case (src)
      SRC_RN:  pick_operand = rn_v;
      SRC_RM:  pick_operand = rm_v;
      SRC_IMM: pick_operand = imm_v;
      default: pick_operand = '0;
    endcase
  endfunction

  logic [DATA_W-1:0] dec_op1;
  logic [DATA_W-1:0] dec_op2;

  assign dec_op1 = pick_operand(dec_src1, rn_val, rm_val, imm);
  assign dec_op2 = pick_operand(dec_src2, rn_val, rm_val, imm);

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic              valid_q, valid_d;
  logic [3:0]        select_q, select_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic [4:0]        rd_q, rd_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic accept;
  logic consume;

  // The slot frees up in the same cycle it is consumed, which gives full
  // throughput with out_ready held high.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign consume  = valid_q && out_ready;

  always_comb begin
    valid_d   = valid_q;
    select_d  = select_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    rd_d      = rd_q;
    illegal_d = illegal_q;

    if (accept) begin
      valid_d   = 1'b1;
      select_d  = dec_select;
      op1_d     = dec_op1;
      op2_d     = dec_op2;
      rd_d      = rd_idx;
      illegal_d = dec_illegal;
    end else if (flush || consume) begin
      // Data outputs keep their last value; only valid drops.
      valid_d = 1'b0;
    end
  end

  // Counting depends only on the output handshake, so a flush in the same
  // cycle as a consume still counts that consume.
  assign cnt_d = consume ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      select_q  <= ALU_AND;
      op1_q     <= '0;
      op2_q     <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples the pre-edge value of every other flop.
      valid_q   <= valid_d;
      select_q  <= select_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign select      = select_q;
  assign input1      = op1_q;
  assign input2      = op2_q;
  assign out_rd      = rd_q;
  assign out_illegal = illegal_q;
  assign issue_count = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Directed bench for alu_issue_stage. A second instance with a 3-bit counter
// shares all inputs, so counter wrap can be reached in a handful of cycles.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADDI = 11'b10010001000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_BAD  = 11'b11111111111;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] opcode;
  logic [4:0]  rn_idx, rm_idx, rd_idx, wb_rd, out_rd;
  logic [63:0] rn_data, rm_data, imm, wb_data, input1, input2;
  logic        wb_we, flush, out_valid, out_ready, out_illegal;
  logic [3:0]  select;
  logic [31:0] issue_count;

  logic        s_in_ready, s_out_valid, s_out_illegal;
  logic [3:0]  s_select;
  logic [63:0] s_input1, s_input2;
  logic [4:0]  s_out_rd;
  logic [2:0]  s_issue_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rn_idx(rn_idx), .rm_idx(rm_idx), .rd_idx(rd_idx),
    .rn_data(rn_data), .rm_data(rm_data), .imm(imm),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .select(select),
    .input1(input1), .input2(input2), .out_rd(out_rd),
    .out_illegal(out_illegal), .issue_count(issue_count)
  );

  alu_issue_stage #(.DATA_W(64), .CNT_W(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .opcode(opcode), .rn_idx(rn_idx), .rm_idx(rm_idx), .rd_idx(rd_idx),
    .rn_data(rn_data), .rm_data(rm_data), .imm(imm),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(s_out_valid), .out_ready(out_ready), .select(s_select),
    .input1(s_input1), .input2(s_input2), .out_rd(s_out_rd),
    .out_illegal(s_out_illegal), .issue_count(s_issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [10:0] op, input logic [4:0] rn, input logic [4:0] rm,
                           input logic [4:0] rd, input logic [63:0] rnd, input logic [63:0] rmd,
                           input logic [63:0] im);
    opcode = op; rn_idx = rn; rm_idx = rm; rd_idx = rd;
    rn_data = rnd; rm_data = rmd; imm = im;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; wb_we = 1'b0; out_ready = 1'b0;
    wb_rd = 5'd0; wb_data = '0;
    set_instr(OP_ADD, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0);
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (select !== 4'b0000 || input1 !== 64'd0 || input2 !== 64'd0) begin
      errors++; $display("FAIL reset_data: select=%b in1=%h in2=%h want 0", select, input1, input2); end
    checks++; if (out_rd !== 5'd0 || out_illegal !== 1'b0 || issue_count !== 32'd0) begin
      errors++; $display("FAIL reset_misc: rd=%0d ill=%0b cnt=%0d want 0", out_rd, out_illegal, issue_count); end
    @(negedge clk); rst_n = 1'b1;
    step();
    exp_cnt = 0;
  endtask

  task automatic test_add();
    out_ready = 1'b0;
    set_instr(OP_ADD, 5'd3, 5'd4, 5'd1, 64'd5, 64'd7, 64'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %0b want 1", out_valid); end
    checks++; if (select !== 4'b0010 || input1 !== 64'd5 || input2 !== 64'd7 || out_rd !== 5'd1) begin
      errors++; $display("FAIL add_data: sel=%b in1=%0d in2=%0d rd=%0d want 0010 5 7 1", select, input1, input2, out_rd); end
    checks++; if (issue_count !== 32'd0) begin errors++; $display("FAIL add_cnt_before: got %0d want 0", issue_count); end
    out_ready = 1'b1;
    step(); exp_cnt++;
    checks++; if (out_valid !== 1'b0 || issue_count !== 32'd1) begin
      errors++; $display("FAIL add_consume: valid=%0b cnt=%0d want 0 1", out_valid, issue_count); end
    checks++; if (input1 !== 64'd5) begin errors++; $display("FAIL add_hold_data: got %0d want 5", input1); end
  endtask

  task automatic test_addi_xzr();
    out_ready = 1'b1;
    set_instr(OP_ADDI, 5'd31, 5'd0, 5'd2, 64'd99, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (select !== 4'b0010 || input1 !== 64'd0 || input2 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL addi_xzr: sel=%b in1=%h in2=%h want 0010 0 ffffffffffffffff", select, input1, input2); end
    step(); exp_cnt++;
  endtask

  task automatic test_forward();
    out_ready = 1'b1;
    set_instr(OP_SUB, 5'd1, 5'd2, 5'd3, 64'd20, 64'd10, 64'd0);
    wb_we = 1'b1; wb_rd = 5'd2; wb_data = 64'd42;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (select !== 4'b0110 || input1 !== 64'd20 || input2 !== 64'd42) begin
      errors++; $display("FAIL fwd_rm: sel=%b in1=%0d in2=%0d want 0110 20 42", select, input1, input2); end
    step(); exp_cnt++;
    wb_rd = 5'd31;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (input2 !== 64'd10) begin errors++; $display("FAIL fwd_xzr: in2=%0d want 10", input2); end
    step(); exp_cnt++;
    wb_rd = 5'd1; wb_data = 64'd77;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0; wb_we = 1'b0;
    checks++; if (input1 !== 64'd77 || input2 !== 64'd10) begin
      errors++; $display("FAIL fwd_rn: in1=%0d in2=%0d want 77 10", input1, input2); end
    step(); exp_cnt++;
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    set_instr(OP_AND, 5'd5, 5'd6, 5'd7, 64'hF0F0, 64'hFF00, 64'd0);
    in_valid = 1'b1;
    step();
    // Next instruction waits upstream; a write-back to the held Rn must not
    // alter the held operand.
    set_instr(OP_ORR, 5'd7, 5'd8, 5'd9, 64'd1, 64'd2, 64'd0);
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 64'd123;
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %0b want 0", i, in_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || select !== 4'b0000 || input1 !== 64'hF0F0 || input2 !== 64'hFF00
                    || out_rd !== 5'd7 || issue_count !== 32'(exp_cnt)) begin
        errors++; $display("FAIL stall_hold[%0d]: v=%0b sel=%b in1=%h in2=%h rd=%0d cnt=%0d want 1 0000 f0f0 ff00 7 %0d",
                           i, out_valid, select, input1, input2, out_rd, issue_count, exp_cnt); end
    end
    wb_we = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %0b want 1", in_ready); end
    step(); exp_cnt++;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || select !== 4'b0001 || input1 !== 64'd1 || input2 !== 64'd2
                  || issue_count !== 32'(exp_cnt)) begin
      errors++; $display("FAIL stall_next: v=%0b sel=%b in1=%0d in2=%0d cnt=%0d want 1 0001 1 2 %0d",
                         out_valid, select, input1, input2, issue_count, exp_cnt); end
    step(); exp_cnt++;
    checks++; if (out_valid !== 1'b0 || issue_count !== 32'(exp_cnt)) begin
      errors++; $display("FAIL stall_drain: v=%0b cnt=%0d want 0 %0d", out_valid, issue_count, exp_cnt); end
  endtask

  task automatic test_flush_illegal();
    out_ready = 1'b0;
    set_instr(OP_LDUR, 5'd9, 5'd0, 5'd4, 64'd1000, 64'd0, 64'd8);
    in_valid = 1'b1;
    step();
    checks++; if (select !== 4'b0010 || input1 !== 64'd1000 || input2 !== 64'd8) begin
      errors++; $display("FAIL ldur: sel=%b in1=%0d in2=%0d want 0010 1000 8", select, input1, input2); end
    set_instr(OP_STUR, 5'd10, 5'd0, 5'd5, 64'd2000, 64'd0, 64'd16);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || input1 !== 64'd1000 || issue_count !== 32'(exp_cnt)) begin
      errors++; $display("FAIL flush_stalled: v=%0b in1=%0d cnt=%0d want 0 1000 %0d", out_valid, input1, issue_count, exp_cnt); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped: v=%0b want 0", out_valid); end
    // Flush in the same cycle as a consume: the consume still counts.
    in_valid = 1'b1;
    step();
    flush = 1'b1; out_ready = 1'b1;
    step(); exp_cnt++;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || issue_count !== 32'(exp_cnt)) begin
      errors++; $display("FAIL flush_consume: v=%0b cnt=%0d want 0 %0d", out_valid, issue_count, exp_cnt); end
    set_instr(OP_BAD, 5'd1, 5'd2, 5'd6, 64'd5, 64'd6, 64'd3);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || select !== 4'b0000 || input1 !== 64'd0 || input2 !== 64'd0) begin
      errors++; $display("FAIL illegal: v=%0b ill=%0b sel=%b in1=%0d in2=%0d want 1 1 0000 0 0",
                         out_valid, out_illegal, select, input1, input2); end
    step(); exp_cnt++;
    checks++; if (issue_count !== 32'(exp_cnt)) begin errors++; $display("FAIL illegal_count: got %0d want %0d", issue_count, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1;
    set_instr(OP_CBZ, 5'd4, 5'd3, 5'd0, 64'd55, 64'd77, 64'd0);
    step();
    checks++; if (out_illegal !== 1'b0 || select !== 4'b0010 || input1 !== 64'd0 || input2 !== 64'd77) begin
      errors++; $display("FAIL cbz: ill=%0b sel=%b in1=%0d in2=%0d want 0 0010 0 77", out_illegal, select, input1, input2); end
    set_instr(OP_ADD, 5'd1, 5'd2, 5'd3, 64'd100, 64'd200, 64'd0);
    step(); exp_cnt++;
    checks++; if (out_valid !== 1'b1 || input1 !== 64'd100 || input2 !== 64'd200 || issue_count !== 32'(exp_cnt)) begin
      errors++; $display("FAIL b2b_1: v=%0b in1=%0d in2=%0d cnt=%0d want 1 100 200 %0d", out_valid, input1, input2, issue_count, exp_cnt); end
    set_instr(OP_SUB, 5'd4, 5'd5, 5'd6, 64'd300, 64'd400, 64'd0);
    step(); exp_cnt++;
    checks++; if (out_valid !== 1'b1 || select !== 4'b0110 || input1 !== 64'd300 || input2 !== 64'd400
                  || out_rd !== 5'd6 || issue_count !== 32'(exp_cnt)) begin
      errors++; $display("FAIL b2b_2: v=%0b sel=%b in1=%0d in2=%0d rd=%0d cnt=%0d want 1 0110 300 400 6 %0d",
                         out_valid, select, input1, input2, out_rd, issue_count, exp_cnt); end
    in_valid = 1'b0;
    step(); exp_cnt++;
    checks++; if (out_valid !== 1'b0 || issue_count !== 32'(exp_cnt)) begin
      errors++; $display("FAIL b2b_drain: v=%0b cnt=%0d want 0 %0d", out_valid, issue_count, exp_cnt); end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    set_instr(OP_ADD, 5'd1, 5'd2, 5'd3, 64'd1, 64'd2, 64'd0);
    for (int i = 0; i < 8 && (exp_cnt % 8) != 7; i++) begin
      in_valid = 1'b1; step();
      in_valid = 1'b0; step(); exp_cnt++;
    end
    checks++; if (s_issue_count !== 3'd7) begin errors++; $display("FAIL wrap_pre: got %0d want 7", s_issue_count); end
    in_valid = 1'b1; step();
    in_valid = 1'b0; step(); exp_cnt++;
    checks++; if (s_issue_count !== 3'd0 || issue_count !== 32'(exp_cnt)) begin
      errors++; $display("FAIL wrap: small=%0d wide=%0d want 0 %0d", s_issue_count, issue_count, exp_cnt); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    set_instr(OP_ORR, 5'd1, 5'd2, 5'd3, 64'd11, 64'd22, 64'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || select !== 4'b0000 || input1 !== 64'd0 || input2 !== 64'd0
                  || out_rd !== 5'd0 || out_illegal !== 1'b0 || issue_count !== 32'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset: v=%0b sel=%b in1=%0d in2=%0d rd=%0d ill=%0b cnt=%0d rdy=%0b want all 0, rdy 1",
                         out_valid, select, input1, input2, out_rd, out_illegal, issue_count, in_ready); end
    @(negedge clk); rst_n = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %0b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_addi_xzr();
    test_forward();
    test_stall();
    test_flush_illegal();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
